itwd_mul00: RTL and testbench

//  Inverse-FFT stage-0 twiddle multiplier: the conjugate-direction mirror of the forward stage-0 twiddle stage.
//  - Consumes 16-lane radix-2 butterfly sum/diff beats from the IFFT stage-0 butterfly.
//  - Multiplies diff lanes by W* = 1 (first half of frame) or +j (second half of frame).
//  - Sum lanes always pass with W* = 1.
//  - Registers all outputs and tracks frame position; feeds IFFT stage-1 butterfly.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/itwd_mul00_if.sv | 40 ++++
 rtl/itwd_beat_cnt.sv | 37 +++
 rtl/itwd_mul00.sv | 114 +++++++++++
 tb/tb_itwd_mul00.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and negation rule for the IFFT stage-0 twiddle multiplier.
// Build option: ITWD00_SAT_EN selects a saturating negation; without it, negation wraps.
package fft_pkg;

    localparam int FFT_WIDTH       = 9;
    localparam int FFT_LANES       = 16;
    localparam int FFT_FRAME_BEATS = 32;
    localparam int FFT_CNT_W       = $clog2(FFT_FRAME_BEATS);

    typedef logic signed [FFT_WIDTH:0] sample_t;

`ifdef ITWD00_SAT_EN
    localparam sample_t SAMPLE_MIN = {1'b1, {FFT_WIDTH{1'b0}}};
    localparam sample_t SAMPLE_MAX = {1'b0, {FFT_WIDTH{1'b1}}};
`endif

    // The only input whose negation overflows is the most negative code.
    function automatic sample_t neg_sample(input sample_t x);
`ifdef ITWD00_SAT_EN
        if (x == SAMPLE_MIN) begin
            return SAMPLE_MAX;
        end
`endif
        return -x;
    endfunction

endpackage

// File: rtl/itwd_mul00_if.sv
// Beat bus between the stage-0 butterfly, the twiddle multiplier and the stage-1 butterfly.
// Build option: ITWD00_SAT_EN adds the o_sat_flag signal.
interface itwd_mul00_if;
    import fft_pkg::*;

    logic                 i_valid;
    logic                 i_clr;
    sample_t              i_bfly_sum_re  [FFT_LANES];
    sample_t              i_bfly_sum_im  [FFT_LANES];
    sample_t              i_bfly_diff_re [FFT_LANES];
    sample_t              i_bfly_diff_im [FFT_LANES];

    logic                 o_valid;
    sample_t              o_sum_re  [FFT_LANES];
    sample_t              o_sum_im  [FFT_LANES];
    sample_t              o_diff_re [FFT_LANES];
    sample_t              o_diff_im [FFT_LANES];
    logic                 o_frame_last;
    logic [FFT_CNT_W-1:0] o_beat_idx;
`ifdef ITWD00_SAT_EN
    logic                 o_sat_flag;
`endif

    modport master (
        output i_valid, i_clr, i_bfly_sum_re, i_bfly_sum_im, i_bfly_diff_re, i_bfly_diff_im,
        input  o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_frame_last, o_beat_idx
`ifdef ITWD00_SAT_EN
        , input o_sat_flag
`endif
    );

    modport slave (
        input  i_valid, i_clr, i_bfly_sum_re, i_bfly_sum_im, i_bfly_diff_re, i_bfly_diff_im,
        output o_valid, o_sum_re, o_sum_im, o_diff_re, o_diff_im, o_frame_last, o_beat_idx
`ifdef ITWD00_SAT_EN
        , output o_sat_flag
`endif
    );

endinterface

// File: rtl/itwd_beat_cnt.sv
// Mod-FFT_FRAME_BEATS beat counter; clr dominates en, count is the index of the next beat.
module itwd_beat_cnt
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    output logic [FFT_CNT_W-1:0] count,
    output logic                 last
);

    logic [FFT_CNT_W-1:0] count_d, count_q;

    // Next count: restart on clr, advance (with wrap) on en, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last  = (count_q == FFT_CNT_W'(FFT_FRAME_BEATS - 1));
    assign count = count_q;

endmodule

// File: rtl/itwd_mul00.sv
// IFFT stage-0 twiddle multiplier: diff lanes x1 in the first half of a frame, x(+j) in the
// second half; sum lanes pass through. One register stage, no backpressure.
// Build option: ITWD00_SAT_EN saturates -(-2^WIDTH) and drives o_sat_flag.
module itwd_mul00
    import fft_pkg::*;
(
    input logic          clk,
    input logic          rst,
    itwd_mul00_if.slave  bus
);

    logic [FFT_CNT_W-1:0] cnt;
    logic                 cnt_last;
    logic                 sel;
    logic                 beat_ok;

    sample_t tw_re [FFT_LANES];
    sample_t tw_im [FFT_LANES];

    sample_t sum_re_d  [FFT_LANES], sum_re_q  [FFT_LANES];
    sample_t sum_im_d  [FFT_LANES], sum_im_q  [FFT_LANES];
    sample_t diff_re_d [FFT_LANES], diff_re_q [FFT_LANES];
    sample_t diff_im_d [FFT_LANES], diff_im_q [FFT_LANES];

    logic                 valid_d, valid_q;
    logic                 last_d, last_q;
    logic [FFT_CNT_W-1:0] idx_d, idx_q;
`ifdef ITWD00_SAT_EN
    logic                 sat_d, sat_q;
`endif

    itwd_beat_cnt u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.i_valid),
        .clr   (bus.i_clr),
        .count (cnt),
        .last  (cnt_last)
    );

    // Twiddle select: second half of the frame rotates the diff by +j.
    always_comb begin
        sel = (cnt >= FFT_CNT_W'(FFT_FRAME_BEATS / 2));
        for (int l = 0; l < FFT_LANES; l++) begin
            tw_re[l] = sel ? neg_sample(bus.i_bfly_diff_im[l]) : bus.i_bfly_diff_re[l];
            tw_im[l] = sel ? bus.i_bfly_diff_re[l] : bus.i_bfly_diff_im[l];
        end
    end

    // Next output state: load on an accepted beat (clear discards it), hold data otherwise.
    always_comb begin
        beat_ok = bus.i_valid && !bus.i_clr;
        valid_d = beat_ok;
        last_d  = beat_ok && cnt_last;
        idx_d   = beat_ok ? cnt : idx_q;
        for (int l = 0; l < FFT_LANES; l++) begin
            sum_re_d[l]  = beat_ok ? bus.i_bfly_sum_re[l] : sum_re_q[l];
            sum_im_d[l]  = beat_ok ? bus.i_bfly_sum_im[l] : sum_im_q[l];
            diff_re_d[l] = beat_ok ? tw_re[l] : diff_re_q[l];
            diff_im_d[l] = beat_ok ? tw_im[l] : diff_im_q[l];
        end
`ifdef ITWD00_SAT_EN
        sat_d = 1'b0;
        for (int l = 0; l < FFT_LANES; l++) begin
            if (beat_ok && sel && (bus.i_bfly_diff_im[l] == SAMPLE_MIN)) begin
                sat_d = 1'b1;
            end
        end
`endif
    end

    // Output registers across all lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            for (int l = 0; l < FFT_LANES; l++) begin
                sum_re_q[l]  <= '0;
                sum_im_q[l]  <= '0;
                diff_re_q[l] <= '0;
                diff_im_q[l] <= '0;
            end
`ifdef ITWD00_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            for (int l = 0; l < FFT_LANES; l++) begin
                sum_re_q[l]  <= sum_re_d[l];
                sum_im_q[l]  <= sum_im_d[l];
                diff_re_q[l] <= diff_re_d[l];
                diff_im_q[l] <= diff_im_d[l];
            end
`ifdef ITWD00_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.o_valid      = valid_q;
    assign bus.o_frame_last = last_q;
    assign bus.o_beat_idx   = idx_q;
    assign bus.o_sum_re     = sum_re_q;
    assign bus.o_sum_im     = sum_im_q;
    assign bus.o_diff_re    = diff_re_q;
    assign bus.o_diff_im    = diff_im_q;
`ifdef ITWD00_SAT_EN
    assign bus.o_sat_flag   = sat_q;
`endif

endmodule

// File: tb/tb_itwd_mul00.sv
// Self-checking bench for itwd_mul00 against a frame-level reference model.
// Build option: ITWD00_SAT_EN switches the expected negation to saturating and checks o_sat_flag.
module tb_itwd_mul00;
    import fft_pkg::*;

`ifdef ITWD00_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    itwd_mul00_if bus_if ();

    itwd_mul00 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the outputs must show after the next edge.
    int                   m_cnt = 0;
    logic                 m_valid = 1'b0;
    logic                 m_last = 1'b0;
    logic                 m_sat = 1'b0;
    logic [FFT_CNT_W-1:0] m_idx = '0;
    sample_t m_sum_re [FFT_LANES];
    sample_t m_sum_im [FFT_LANES];
    sample_t m_diff_re [FFT_LANES];
    sample_t m_diff_im [FFT_LANES];

    // Arithmetic negation reduced to the sample range (wrap or saturate).
    function automatic sample_t ref_neg(input sample_t x);
        int v;
        v = -int'(x);
        if (v > (2 ** FFT_WIDTH) - 1) begin
            v = SAT ? (2 ** FFT_WIDTH) - 1 : v - (2 ** (FFT_WIDTH + 1));
        end
        return sample_t'(v);
    endfunction

    // Advance model with current inputs, then clock the DUT and settle.
    task automatic tick(input bit r);
        bit second;
        rst = r;
        if (r) begin
            m_cnt = 0; m_valid = 0; m_last = 0; m_idx = '0; m_sat = 0;
            for (int l = 0; l < FFT_LANES; l++) begin
                m_sum_re[l] = '0; m_sum_im[l] = '0; m_diff_re[l] = '0; m_diff_im[l] = '0;
            end
        end else if (bus_if.i_clr) begin
            m_cnt = 0; m_valid = 0; m_last = 0; m_sat = 0;
        end else if (bus_if.i_valid) begin
            second = (m_cnt >= FFT_FRAME_BEATS / 2);
            m_sat  = 0;
            for (int l = 0; l < FFT_LANES; l++) begin
                m_sum_re[l] = bus_if.i_bfly_sum_re[l];
                m_sum_im[l] = bus_if.i_bfly_sum_im[l];
                if (second) begin
                    m_diff_re[l] = ref_neg(bus_if.i_bfly_diff_im[l]);
                    m_diff_im[l] = bus_if.i_bfly_diff_re[l];
                    if (SAT && int'(bus_if.i_bfly_diff_im[l]) == -(2 ** FFT_WIDTH)) m_sat = 1;
                end else begin
                    m_diff_re[l] = bus_if.i_bfly_diff_re[l];
                    m_diff_im[l] = bus_if.i_bfly_diff_im[l];
                end
            end
            m_idx   = FFT_CNT_W'(m_cnt);
            m_last  = (m_cnt == FFT_FRAME_BEATS - 1);
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % FFT_FRAME_BEATS;
        end else begin
            m_valid = 0; m_last = 0; m_sat = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int l = 0; l < FFT_LANES; l++) begin
            bus_if.i_bfly_sum_re[l]  = sample_t'($urandom);
            bus_if.i_bfly_sum_im[l]  = sample_t'($urandom);
            bus_if.i_bfly_diff_re[l] = sample_t'($urandom);
            bus_if.i_bfly_diff_im[l] = sample_t'($urandom);
        end
    endtask

    task automatic test_reset();
        int bad;
        bus_if.i_valid = 1'b0;
        bus_if.i_clr   = 1'b0;
        rand_inputs();
        for (int c = 0; c < 3; c++) begin
            tick(1'b1);
            bad = 0;
            for (int l = 0; l < FFT_LANES; l++) begin
                if (bus_if.o_sum_re[l] !== '0 || bus_if.o_sum_im[l] !== '0 ||
                    bus_if.o_diff_re[l] !== '0 || bus_if.o_diff_im[l] !== '0) bad++;
            end
            checks++;
            if (bus_if.o_valid !== 1'b0 || bus_if.o_frame_last !== 1'b0 ||
                bus_if.o_beat_idx !== '0 || bad != 0) begin
                failures++;
                $display("FAIL reset cyc %0d: valid=%b last=%b idx=%0d nonzero_lanes=%0d, required all 0",
                         c, bus_if.o_valid, bus_if.o_frame_last, bus_if.o_beat_idx, bad);
            end
        end
    endtask

    task automatic test_twiddle();
        tick(1'b1);
        bus_if.i_valid = 1'b1;
        for (int b = 0; b < FFT_FRAME_BEATS; b++) begin
            rand_inputs();
            for (int l = 0; l < FFT_LANES; l++) begin
                bus_if.i_bfly_diff_re[l] = sample_t'(l + 1);
                bus_if.i_bfly_diff_im[l] = sample_t'(-(l + 1));
            end
            tick(1'b0);
            checks++;
            if (bus_if.o_valid !== m_valid || bus_if.o_frame_last !== m_last ||
                bus_if.o_beat_idx !== m_idx) begin
                failures++;
                $display("FAIL twiddle_ctrl beat %0d: valid=%b last=%b idx=%0d, required %b %b %0d",
                         b, bus_if.o_valid, bus_if.o_frame_last, bus_if.o_beat_idx, m_valid, m_last, m_idx);
            end
            for (int l = 0; l < FFT_LANES; l++) begin
                checks++;
                if (bus_if.o_sum_re[l] !== m_sum_re[l] || bus_if.o_sum_im[l] !== m_sum_im[l] ||
                    bus_if.o_diff_re[l] !== m_diff_re[l] || bus_if.o_diff_im[l] !== m_diff_im[l]) begin
                    failures++;
                    $display("FAIL twiddle_data beat %0d lane %0d: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                             b, l, bus_if.o_sum_re[l], bus_if.o_sum_im[l], bus_if.o_diff_re[l], bus_if.o_diff_im[l],
                             m_sum_re[l], m_sum_im[l], m_diff_re[l], m_diff_im[l]);
                end
            end
            checks++;
            if (bus_if.o_diff_re[5] !== sample_t'(6) ||
                bus_if.o_diff_im[5] !== sample_t'((b < FFT_FRAME_BEATS / 2) ? -6 : 6) ||
                bus_if.o_frame_last !== (b == FFT_FRAME_BEATS - 1)) begin
                failures++;
                $display("FAIL twiddle_const beat %0d: lane5 re=%0d im=%0d last=%b, required re=6 im=%0d last=%b",
                         b, bus_if.o_diff_re[5], bus_if.o_diff_im[5], bus_if.o_frame_last,
                         (b < FFT_FRAME_BEATS / 2) ? -6 : 6, (b == FFT_FRAME_BEATS - 1));
            end
        end
        bus_if.i_valid = 1'b0;
    endtask

    task automatic test_sat();
        sample_t exp_re;
        tick(1'b1);
        bus_if.i_valid = 1'b1;
        for (int b = 0; b < FFT_FRAME_BEATS / 2; b++) begin
            rand_inputs();
            tick(1'b0);
        end
        rand_inputs();
        bus_if.i_bfly_diff_im[0] = sample_t'(-(2 ** FFT_WIDTH));
`ifdef ITWD00_SAT_EN
        exp_re = sample_t'((2 ** FFT_WIDTH) - 1);
`else
        exp_re = sample_t'(-(2 ** FFT_WIDTH));
`endif
        tick(1'b0);
        checks++;
        if (bus_if.o_diff_re[0] !== exp_re || bus_if.o_diff_im[0] !== bus_if.i_bfly_diff_re[0]) begin
            failures++;
            $display("FAIL sat_neg: re=%0d im=%0d, required re=%0d im=%0d",
                     bus_if.o_diff_re[0], bus_if.o_diff_im[0], exp_re, bus_if.i_bfly_diff_re[0]);
        end
`ifdef ITWD00_SAT_EN
        checks++;
        if (bus_if.o_sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_flag_set: got %b, required 1", bus_if.o_sat_flag);
        end
        rand_inputs();
        for (int l = 0; l < FFT_LANES; l++) bus_if.i_bfly_diff_im[l][FFT_WIDTH] = 1'b0;
        tick(1'b0);
        checks++;
        if (bus_if.o_sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_flag_clear: got %b, required 0", bus_if.o_sat_flag);
        end
`endif
        bus_if.i_valid = 1'b0;
    endtask

    task automatic test_gaps();
        int vcount = 0;
        bus_if.i_valid = 1'b0;
        tick(1'b1);
        for (int c = 0; c < 3 * (FFT_FRAME_BEATS + 2); c++) begin
            bus_if.i_valid = ((c % 3) == 0);
            rand_inputs();
            tick(1'b0);
            checks++;
            if (bus_if.o_valid !== m_valid || bus_if.o_frame_last !== m_last ||
                bus_if.o_beat_idx !== m_idx) begin
                failures++;
                $display("FAIL gaps_ctrl cyc %0d: valid=%b last=%b idx=%0d, required %b %b %0d",
                         c, bus_if.o_valid, bus_if.o_frame_last, bus_if.o_beat_idx, m_valid, m_last, m_idx);
            end
            for (int l = 0; l < FFT_LANES; l++) begin
                checks++;
                if (bus_if.o_sum_re[l] !== m_sum_re[l] || bus_if.o_sum_im[l] !== m_sum_im[l] ||
                    bus_if.o_diff_re[l] !== m_diff_re[l] || bus_if.o_diff_im[l] !== m_diff_im[l]) begin
                    failures++;
                    $display("FAIL gaps_data cyc %0d lane %0d: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                             c, l, bus_if.o_sum_re[l], bus_if.o_sum_im[l], bus_if.o_diff_re[l], bus_if.o_diff_im[l],
                             m_sum_re[l], m_sum_im[l], m_diff_re[l], m_diff_im[l]);
                end
            end
`ifdef ITWD00_SAT_EN
            checks++;
            if (bus_if.o_sat_flag !== m_sat) begin
                failures++;
                $display("FAIL gaps_sat cyc %0d: got %b, required %b", c, bus_if.o_sat_flag, m_sat);
            end
`endif
            if (bus_if.i_valid) begin
                if (vcount == FFT_FRAME_BEATS / 2) begin
                    checks++;
                    if (bus_if.o_beat_idx !== FFT_CNT_W'(FFT_FRAME_BEATS / 2) ||
                        bus_if.o_diff_im[3] !== bus_if.i_bfly_diff_re[3]) begin
                        failures++;
                        $display("FAIL gaps_switch: idx=%0d im=%0d, required idx=%0d im=%0d",
                                 bus_if.o_beat_idx, bus_if.o_diff_im[3], FFT_FRAME_BEATS / 2,
                                 bus_if.i_bfly_diff_re[3]);
                    end
                end
                vcount++;
            end
        end
        bus_if.i_valid = 1'b0;
    endtask

    task automatic test_clear();
        int bad;
        tick(1'b1);
        bus_if.i_valid = 1'b1;
        for (int b = 0; b < 20; b++) begin
            rand_inputs();
            tick(1'b0);
        end
        rand_inputs();
        bus_if.i_clr = 1'b1;
        tick(1'b0);
        checks++;
        if (bus_if.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_valid: got %b, required 0", bus_if.o_valid);
        end
        bus_if.i_clr = 1'b0;
        rand_inputs();
        tick(1'b0);
        bad = 0;
        for (int l = 0; l < FFT_LANES; l++) begin
            if (bus_if.o_diff_re[l] !== bus_if.i_bfly_diff_re[l] ||
                bus_if.o_diff_im[l] !== bus_if.i_bfly_diff_im[l]) bad++;
        end
        checks++;
        if (bus_if.o_valid !== 1'b1 || bus_if.o_beat_idx !== '0 || bad != 0) begin
            failures++;
            $display("FAIL clear_restart: valid=%b idx=%0d bad_lanes=%0d, required valid=1 idx=0 bad_lanes=0",
                     bus_if.o_valid, bus_if.o_beat_idx, bad);
        end
        bus_if.i_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick(1'b1);
        bus_if.i_valid = 1'b1;
        for (int b = 0; b < 10; b++) begin
            rand_inputs();
            tick(1'b0);
        end
        rand_inputs();
        tick(1'b1);
        checks++;
        if (bus_if.o_valid !== 1'b0 || bus_if.o_beat_idx !== '0 || bus_if.o_diff_re[0] !== '0 ||
            bus_if.o_sum_im[FFT_LANES - 1] !== '0) begin
            failures++;
            $display("FAIL rstmid_zero: valid=%b idx=%0d dre0=%0d sim15=%0d, required all 0",
                     bus_if.o_valid, bus_if.o_beat_idx, bus_if.o_diff_re[0], bus_if.o_sum_im[FFT_LANES - 1]);
        end
        for (int b = 0; b < FFT_FRAME_BEATS + 1; b++) begin
            rand_inputs();
            tick(1'b0);
            checks++;
            if (bus_if.o_valid !== m_valid || bus_if.o_frame_last !== m_last ||
                bus_if.o_beat_idx !== m_idx || bus_if.o_beat_idx !== FFT_CNT_W'(b)) begin
                failures++;
                $display("FAIL rstmid_ctrl beat %0d: valid=%b last=%b idx=%0d, required %b %b %0d",
                         b, bus_if.o_valid, bus_if.o_frame_last, bus_if.o_beat_idx, m_valid, m_last, m_idx);
            end
            for (int l = 0; l < FFT_LANES; l++) begin
                checks++;
                if (bus_if.o_sum_re[l] !== m_sum_re[l] || bus_if.o_sum_im[l] !== m_sum_im[l] ||
                    bus_if.o_diff_re[l] !== m_diff_re[l] || bus_if.o_diff_im[l] !== m_diff_im[l]) begin
                    failures++;
                    $display("FAIL rstmid_data beat %0d lane %0d: got %0d %0d %0d %0d, required %0d %0d %0d %0d",
                             b, l, bus_if.o_sum_re[l], bus_if.o_sum_im[l], bus_if.o_diff_re[l], bus_if.o_diff_im[l],
                             m_sum_re[l], m_sum_im[l], m_diff_re[l], m_diff_im[l]);
                end
            end
        end
        bus_if.i_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus_if.i_valid = 1'b0;
        bus_if.i_clr   = 1'b0;
        rand_inputs();
        test_reset();
        test_twiddle();
        test_sat();
        test_gaps();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
